alarm_bank: RTL and testbench
=============================

# alarm_bank

Parametrised multi-channel alarm block: holds NUM_ALARMS independently settable, independently enabled alarm times, compares each against the running time of day, and runs a per-channel ring/snooze state machine with a ring timeout. It sits beside the time-of-day counter. It consumes the current minute-of-day and a 1 Hz tick, and drives the display mux (selected alarm in 12-hour BCD) and the buzzer (ring flags).

## Interface
- NUM_ALARMS, 4: number of alarm channels (1..16).
- START_HOURS, 0: reset hour for every channel (0..23).
- START_MINUTES, 0: reset minute for every channel (0..59).
- SNOOZE_MINUTES, 9: snooze length in minutes (1..59).
- RING_SECONDS, 60: ringing auto-timeout in seconds (1..3600).
- SEL_W, $clog2(NUM_ALARMS) with minimum 1: select width (derived, not overridden).

Clock is i_Clk. Reset is synchronous, active-high, and named i_Reset.
- i_Clk  in  1  system clock (5 MHz); all state changes on its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Sel  in  SEL_W  channel addressed by edit, toggle and display; values ≥ NUM_ALARMS are ignored (no edit, display shows channel 0).
- i_Minutes_Inc / i_Minutes_Dec  in  1 each  single-cycle pulses; edit the selected channel's minutes.
- i_Hours_Inc / i_Hours_Dec  in  1 each  single-cycle pulses; edit the selected channel's hours.
- i_Enable_Toggle  in  1  pulse; toggles the selected channel's enable.
- i_Snooze  in  1  pulse; snoozes every RINGING channel.
- i_Dismiss  in  1  pulse; dismisses every RINGING or SNOOZED channel.
- i_Time_Minutes  in  11  current minute-of-day, 0..1439.
- i_Second_Tick  in  1  one-cycle pulse per second.
- o_Alarm_BCD  out  16  selected alarm time as {H1,H0,M1,M0} in 12-hour format.
- o_PM  out  1  selected alarm hour ≥ 12.
- o_Enabled  out  NUM_ALARMS  per-channel enable.
- o_Ring  out  NUM_ALARMS  per-channel RINGING.
- o_Ringing  out  1  OR of o_Ring.

## Operation
- Per-channel storage: hours (5 bits, 0..23) and minutes (6 bits, 0..59). The compare value is hours*60+minutes (11 bits).
- Edits apply to the selected channel only:
  - Minutes wrap 59↔0 with no carry into hours.
  - Hours wrap 23↔0.
  - Inc and Dec of the same field in the same cycle: no change.
  - Minute and hour edits in the same cycle both apply.
  - Edits never change the channel's state.
- States per channel: DISABLED, ARMED, RINGING, SNOOZED.
- DISABLED → ARMED: enable toggle on the selected channel.
- Any state → DISABLED: enable toggle on the selected channel. This has top priority.
- ARMED → RINGING: all of the following in the same cycle:
  - i_Time_Minutes differs from its value registered on the previous cycle (minute rollover);
  - the new i_Time_Minutes equals the channel's compare value.
  - Consequences: setting an alarm to the current minute does not fire, and a dismissed alarm cannot re-fire within the same minute.
- RINGING → ARMED: i_Dismiss, or ring counter reaches RING_SECONDS.
- RINGING → SNOOZED: i_Snooze.
- SNOOZED → ARMED: i_Dismiss.
- SNOOZED → RINGING: snooze counter reaches SNOOZE_MINUTES*60.
- Priority order: toggle-disable > dismiss > snooze > timeout/expiry > fire.
- Counters:
  - One per-channel tick counter, cleared on entry to RINGING or SNOOZED.
  - It increments only on i_Second_Tick.
  - Width covers max(RING_SECONDS, SNOOZE_MINUTES*60).
- Display conversion of the selected channel:
  - Hour 0 shows 12, AM.
  - Hours 1..12 show as-is.
  - Hours 13..23 show hour−12.
  - o_PM = hour ≥ 12.
  - Each BCD digit is 4 bits.

## Timing
- Reset values:
  - all channels hold START_HOURS:START_MINUTES, state DISABLED, counters 0;
  - o_Enabled = 0, o_Ring = 0, o_Ringing = 0;
  - o_Alarm_BCD and o_PM reflect channel 0's reset time one cycle after reset deasserts.
- Latencies:
  - Edit pulse at cycle N: new stored value at N+1, o_Alarm_BCD updated at N+2 (registered display).
  - Fire: i_Time_Minutes changes at cycle N, o_Ring high at N+1.
  - Dismiss/Snooze at cycle N: o_Ring low at N+1.
  - Timeout: the RING_SECONDS-th tick after entry drops o_Ring on the following cycle.
- Reset asserted mid-ring or mid-snooze: every channel returns to DISABLED on the next edge.
- Pending counts are discarded on reset.
- i_Sel change at cycle N: display follows at N+2.

## Structure
- Package alarm_bank_pkg holds:
  - the state typedef (DISABLED/ARMED/RINGING/SNOOZED);
  - constants MINUTES_PER_DAY = 1440, HOURS_PER_DAY = 24, MINUTES_PER_HOUR = 60;
  - a 24h→12h BCD conversion function.
- Sub-module alarm_channel: stores the time, holds the FSM, holds the tick counter, and produces the compare.
- Top level: generates NUM_ALARMS channels, decodes i_Sel into per-channel edit/toggle strobes, registers i_Time_Minutes for rollover detection, and registers the display mux.

## Test plan
- Set channel 1 to 07:30, enable it, drive i_Time_Minutes 449→450 → o_Ring = 4'b0010 one cycle later, o_Ringing = 1.
- While ringing, pulse i_Snooze, then 540 second ticks → RINGING again. Pulse i_Dismiss → o_Ring = 0. Holding i_Time_Minutes at 450 → no re-fire.
- Ring with no input for 60 ticks → auto-ARMED. Next day's 449→450 → fires again.
- Edit checks:
  - Minutes inc from 59 → 00 with hours unchanged.
  - Hours dec from 0 → 23, o_Alarm_BCD = 16'h1100, o_PM = 1.
  - Inc and dec together → unchanged.
- Hour display checks:
  - Hour 0 → o_Alarm_BCD = 16'h1200, o_PM = 0.
  - Hour 13:05 → 16'h0105, o_PM = 1.
- Channels 0 and 2 both at 06:00 fire together. Toggle on channel 0 in the same cycle as i_Dismiss → channel 0 DISABLED, channel 2 ARMED. Assert i_Reset during a ring → all outputs at reset values next cycle.

Source files
------------

// File: rtl/alarm_bank_pkg.sv
// alarm_bank shared types, day/time constants and
// the 24h to 12h BCD display conversion.
package alarm_bank_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZED  = 2'd3
  } alarm_state_t;

  localparam int MINUTES_PER_DAY  = 1440;
  localparam int HOURS_PER_DAY    = 24;
  localparam int MINUTES_PER_HOUR = 60;

  // returns {H1,H0,M1,M0}; midnight hour shows as 12
  function automatic logic [15:0] to_bcd12(
    input logic [4:0] hours,
    input logic [5:0] minutes
  );
    logic [3:0] h12;
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    unique case (1'b1)
      (hours == 5'd0): h12 = 4'd12;
      (hours > 5'd12): h12 = 4'(hours - 5'd12);
      default:         h12 = 4'(hours);
    endcase
    h1 = (h12 >= 4'd10) ? 4'd1 : 4'd0;
    h0 = (h12 >= 4'd10) ? h12 - 4'd10 : h12;
    m1 = 4'(minutes / 6'd10);
    m0 = 4'(minutes % 6'd10);
    return {h1, h0, m1, m0};
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored time, enable/ring/snooze
// state machine and the shared ring/snooze tick counter.
module alarm_channel
  import alarm_bank_pkg::*;
#(
  parameter int START_HOURS    = 0,
  parameter int START_MINUTES  = 0,
  parameter int SNOOZE_MINUTES = 9,
  parameter int RING_SECONDS   = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        min_inc,
  input  logic        min_dec,
  input  logic        hr_inc,
  input  logic        hr_dec,
  input  logic        toggle,
  input  logic        snooze,
  input  logic        dismiss,
  input  logic        second_tick,
  input  logic        rollover,
  input  logic [10:0] time_minutes,
  output logic [4:0]  hours,
  output logic [5:0]  minutes,
  output logic        enabled,
  output logic        ring
);

  localparam int SNZ_TICKS =
    SNOOZE_MINUTES * MINUTES_PER_HOUR;
  localparam int CNT_MAX =
    (RING_SECONDS > SNZ_TICKS) ? RING_SECONDS : SNZ_TICKS;
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [5:0] MIN_LAST =
    6'(MINUTES_PER_HOUR - 1);
  localparam logic [4:0] HR_LAST =
    5'(HOURS_PER_DAY - 1);

  alarm_state_t state;
  alarm_state_t state_nx;
  logic [CW-1:0] cnt;
  logic [10:0]   cmp;
  logic          fire;
  logic          ring_done;
  logic          snz_done;
  logic          enter_cnt;
  logic          counting;

  assign cmp = 11'(hours) * 11'(MINUTES_PER_HOUR)
             + 11'(minutes);
  assign fire = rollover && (time_minutes == cmp);
  assign ring_done = second_tick
    && (cnt == CW'(RING_SECONDS - 1));
  assign snz_done = second_tick
    && (cnt == CW'(SNZ_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= DISABLED;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (toggle) begin
      state_nx = (state == DISABLED) ? ARMED : DISABLED;
    end else begin
      case (state)
        RINGING: begin
          if (dismiss)        state_nx = ARMED;
          else if (snooze)    state_nx = SNOOZED;
          else if (ring_done) state_nx = ARMED;
        end
        SNOOZED: begin
          if (dismiss)       state_nx = ARMED;
          else if (snz_done) state_nx = RINGING;
        end
        ARMED: begin
          if (fire) state_nx = RINGING;
        end
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    enabled   = (state != DISABLED);
    ring      = (state == RINGING);
    counting  = (state == RINGING) || (state == SNOOZED);
    enter_cnt = (state_nx != state)
      && ((state_nx == RINGING) || (state_nx == SNOOZED));
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (enter_cnt)
      cnt <= '0;
    else if (second_tick && counting)
      cnt <= cnt + 1'b1;
  end

  // fields wrap independently; no carry between them
  always_ff @(posedge clk) begin
    if (rst) begin
      hours   <= 5'(START_HOURS);
      minutes <= 6'(START_MINUTES);
    end else begin
      if (min_inc && !min_dec)
        minutes <= (minutes == MIN_LAST) ? 6'd0
                 : minutes + 6'd1;
      else if (min_dec && !min_inc)
        minutes <= (minutes == 6'd0) ? MIN_LAST
                 : minutes - 6'd1;
      if (hr_inc && !hr_dec)
        hours <= (hours == HR_LAST) ? 5'd0
               : hours + 5'd1;
      else if (hr_dec && !hr_inc)
        hours <= (hours == 5'd0) ? HR_LAST
               : hours - 5'd1;
    end
  end

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel alarm bank: per-channel edit strobes,
// minute rollover detect and registered 12h display.
module alarm_bank
  import alarm_bank_pkg::*;
#(
  parameter int NUM_ALARMS     = 4,
  parameter int START_HOURS    = 0,
  parameter int START_MINUTES  = 0,
  parameter int SNOOZE_MINUTES = 9,
  parameter int RING_SECONDS   = 60,
  localparam int SEL_W =
    (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic [SEL_W-1:0]      i_Sel,
  input  logic                  i_Minutes_Inc,
  input  logic                  i_Minutes_Dec,
  input  logic                  i_Hours_Inc,
  input  logic                  i_Hours_Dec,
  input  logic                  i_Enable_Toggle,
  input  logic                  i_Snooze,
  input  logic                  i_Dismiss,
  input  logic [10:0]           i_Time_Minutes,
  input  logic                  i_Second_Tick,
  output logic [15:0]           o_Alarm_BCD,
  output logic                  o_PM,
  output logic [NUM_ALARMS-1:0] o_Enabled,
  output logic [NUM_ALARMS-1:0] o_Ring,
  output logic                  o_Ringing
);

  logic [10:0]           time_q;
  logic                  rollover;
  logic [NUM_ALARMS-1:0] hit;
  logic [4:0]            hours   [NUM_ALARMS];
  logic [5:0]            minutes [NUM_ALARMS];
  logic [4:0]            hr_sel;
  logic [5:0]            mn_sel;

  always_ff @(posedge i_Clk) begin
    time_q <= i_Time_Minutes;
  end

  assign rollover = (i_Time_Minutes != time_q);

  // out-of-range selects match no channel
  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++)
      hit[i] = (i_Sel == SEL_W'(i));
  end

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
    alarm_channel #(
      .START_HOURS    (START_HOURS),
      .START_MINUTES  (START_MINUTES),
      .SNOOZE_MINUTES (SNOOZE_MINUTES),
      .RING_SECONDS   (RING_SECONDS)
    ) u_ch (
      .clk          (i_Clk),
      .rst          (i_Reset),
      .min_inc      (i_Minutes_Inc & hit[g]),
      .min_dec      (i_Minutes_Dec & hit[g]),
      .hr_inc       (i_Hours_Inc & hit[g]),
      .hr_dec       (i_Hours_Dec & hit[g]),
      .toggle       (i_Enable_Toggle & hit[g]),
      .snooze       (i_Snooze),
      .dismiss      (i_Dismiss),
      .second_tick  (i_Second_Tick),
      .rollover     (rollover),
      .time_minutes (i_Time_Minutes),
      .hours        (hours[g]),
      .minutes      (minutes[g]),
      .enabled      (o_Enabled[g]),
      .ring         (o_Ring[g])
    );
  end

  assign o_Ringing = |o_Ring;

  always_comb begin
    hr_sel = hours[0];
    mn_sel = minutes[0];
    for (int i = 1; i < NUM_ALARMS; i++) begin
      if (hit[i]) begin
        hr_sel = hours[i];
        mn_sel = minutes[i];
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Alarm_BCD <= to_bcd12(5'(START_HOURS),
                              6'(START_MINUTES));
      o_PM        <= (START_HOURS >= 12);
    end else begin
      o_Alarm_BCD <= to_bcd12(hr_sel, mn_sel);
      o_PM        <= (hr_sel >= 5'd12);
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank with a minute-of-day
// behavioural model checked every cycle.
module tb_alarm_bank;

  localparam int N    = 4;
  localparam int SH   = 0;
  localparam int SM   = 0;
  localparam int SNZ  = 9;
  localparam int RS   = 60;
  localparam int OFF  = 0;
  localparam int ARM  = 1;
  localparam int RNG  = 2;
  localparam int SNZS = 3;

  logic        i_Clk = 0;
  logic        i_Reset;
  logic [1:0]  i_Sel;
  logic        i_Minutes_Inc, i_Minutes_Dec;
  logic        i_Hours_Inc, i_Hours_Dec;
  logic        i_Enable_Toggle, i_Snooze, i_Dismiss;
  logic [10:0] i_Time_Minutes;
  logic        i_Second_Tick;
  logic [15:0] o_Alarm_BCD;
  logic        o_PM;
  logic [N-1:0] o_Enabled, o_Ring;
  logic        o_Ringing;

  alarm_bank #(
    .NUM_ALARMS(N), .START_HOURS(SH), .START_MINUTES(SM),
    .SNOOZE_MINUTES(SNZ), .RING_SECONDS(RS)
  ) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Sel(i_Sel),
    .i_Minutes_Inc(i_Minutes_Inc),
    .i_Minutes_Dec(i_Minutes_Dec),
    .i_Hours_Inc(i_Hours_Inc), .i_Hours_Dec(i_Hours_Dec),
    .i_Enable_Toggle(i_Enable_Toggle),
    .i_Snooze(i_Snooze), .i_Dismiss(i_Dismiss),
    .i_Time_Minutes(i_Time_Minutes),
    .i_Second_Tick(i_Second_Tick),
    .o_Alarm_BCD(o_Alarm_BCD), .o_PM(o_PM),
    .o_Enabled(o_Enabled), .o_Ring(o_Ring),
    .o_Ringing(o_Ringing)
  );

  always #100 i_Clk = ~i_Clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bcd12(int h, int m);
    int t;
    t = h % 12;
    if (t == 0) t = 12;
    return 16'(((t / 10) << 12) | ((t % 10) << 8)
             | ((m / 10) << 4) | (m % 10));
  endfunction

  // model: alarm time, state, ticks seen since entry
  int mh[N], mm[N], ms[N], me[N];
  int prev_t, s, ns, roll;
  logic [15:0] e_bcd;
  logic        e_pm;
  bit          mvalid = 0;

  always @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int c = 0; c < N; c++) begin
        mh[c] = SH; mm[c] = SM; ms[c] = OFF; me[c] = 0;
      end
      prev_t = int'(i_Time_Minutes);
      e_bcd  = bcd12(SH, SM);
      e_pm   = (SH >= 12);
      mvalid = 1;
    end else begin
      s = (int'(i_Sel) < N) ? int'(i_Sel) : 0;
      e_bcd = bcd12(mh[s], mm[s]);
      e_pm  = (mh[s] >= 12);
      roll  = (int'(i_Time_Minutes) != prev_t);
      prev_t = int'(i_Time_Minutes);
      for (int c = 0; c < N; c++) begin
        ns = ms[c];
        if (i_Enable_Toggle && int'(i_Sel) == c)
          ns = (ms[c] == OFF) ? ARM : OFF;
        else if (i_Dismiss && (ms[c] == RNG || ms[c] == SNZS))
          ns = ARM;
        else if (i_Snooze && ms[c] == RNG)
          ns = SNZS;
        else if (ms[c] == RNG && i_Second_Tick
                 && me[c] + 1 >= RS)
          ns = ARM;
        else if (ms[c] == SNZS && i_Second_Tick
                 && me[c] + 1 >= SNZ * 60)
          ns = RNG;
        else if (ms[c] == ARM && roll != 0
                 && int'(i_Time_Minutes) == mh[c] * 60 + mm[c])
          ns = RNG;
        if (ns != ms[c] && (ns == RNG || ns == SNZS))
          me[c] = 0;
        else if (i_Second_Tick)
          me[c]++;
        ms[c] = ns;
      end
      if (int'(i_Sel) < N) begin
        s = int'(i_Sel);
        mm[s] = (mm[s] + int'(i_Minutes_Inc)
                 - int'(i_Minutes_Dec) + 60) % 60;
        mh[s] = (mh[s] + int'(i_Hours_Inc)
                 - int'(i_Hours_Dec) + 24) % 24;
      end
    end
  end

  logic [N-1:0] x_ring, x_en;

  always @(negedge i_Clk) begin
    if (mvalid) begin
      for (int c = 0; c < N; c++) begin
        x_ring[c] = (ms[c] == RNG);
        x_en[c]   = (ms[c] != OFF);
      end
      chk("ring", 32'(o_Ring), 32'(x_ring));
      chk("enabled", 32'(o_Enabled), 32'(x_en));
      chk("ringing", 32'(o_Ringing), 32'(|x_ring));
      chk("bcd", 32'(o_Alarm_BCD), 32'(e_bcd));
      chk("pm", 32'(o_PM), 32'(e_pm));
    end
  end

  task automatic cyc();
    @(negedge i_Clk);
  endtask

  task automatic clr();
    i_Minutes_Inc = 0; i_Minutes_Dec = 0;
    i_Hours_Inc = 0; i_Hours_Dec = 0;
    i_Enable_Toggle = 0; i_Snooze = 0;
    i_Dismiss = 0; i_Second_Tick = 0;
  endtask

  task automatic edit(int ch, bit mi, bit md,
                      bit hi, bit hd);
    i_Sel = 2'(ch);
    i_Minutes_Inc = mi; i_Minutes_Dec = md;
    i_Hours_Inc = hi; i_Hours_Dec = hd;
    cyc();
    clr();
  endtask

  task automatic set_hm(int ch, int h, int m);
    int dh, dm;
    dh = (h - mh[ch] + 24) % 24;
    dm = (m - mm[ch] + 60) % 60;
    for (int k = 0; k < 60; k++)
      if (k < dh || k < dm)
        edit(ch, k < dm, 0, k < dh, 0);
  endtask

  task automatic toggle(int ch);
    i_Sel = 2'(ch);
    i_Enable_Toggle = 1;
    cyc();
    clr();
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) begin
      i_Second_Tick = 1;
      cyc();
      i_Second_Tick = 0;
    end
  endtask

  task automatic set_time(int t);
    i_Time_Minutes = 11'(t);
    cyc();
  endtask

  initial begin
    clr();
    i_Reset = 1;
    i_Sel = 0;
    i_Time_Minutes = 11'd449;
    cyc(); cyc(); cyc();
    chk("rst_bcd", 32'(o_Alarm_BCD), 32'h1200);
    chk("rst_pm", 32'(o_PM), 0);
    chk("rst_en", 32'(o_Enabled), 0);
    chk("rst_ring", 32'(o_Ring), 0);
    i_Reset = 0;
    cyc();

    set_hm(1, 7, 30);
    cyc();
    chk("disp_0730", 32'(o_Alarm_BCD), 32'h0730);
    toggle(1);
    chk("en_ch1", 32'(o_Enabled), 32'b0010);
    set_time(450);
    chk("fire_ch1", 32'(o_Ring), 32'b0010);
    chk("ringing", 32'(o_Ringing), 1);

    i_Snooze = 1; cyc(); clr();
    chk("snoozed", 32'(o_Ring), 0);
    ticks(SNZ * 60 - 1);
    chk("snz_539", 32'(o_Ring), 0);
    ticks(1);
    chk("snz_540", 32'(o_Ring), 32'b0010);
    i_Dismiss = 1; cyc(); clr();
    chk("dismiss", 32'(o_Ring), 0);
    repeat (5) cyc();
    chk("no_refire", 32'(o_Ring), 0);

    set_time(1439);
    set_time(449);
    set_time(450);
    chk("fire_day2", 32'(o_Ring), 32'b0010);
    ticks(RS - 1);
    chk("ring_59", 32'(o_Ring), 32'b0010);
    ticks(1);
    chk("timeout", 32'(o_Ring), 0);
    set_time(449);
    set_time(450);
    chk("fire_day3", 32'(o_Ring), 32'b0010);
    i_Dismiss = 1; cyc(); clr();

    set_hm(3, 5, 59);
    edit(3, 1, 0, 0, 0);
    cyc();
    chk("min_wrap", 32'(o_Alarm_BCD), 32'h0500);
    set_hm(3, 0, 0);
    edit(3, 0, 0, 0, 1);
    cyc();
    chk("hr_wrap", 32'(o_Alarm_BCD), 32'h1100);
    chk("hr_wrap_pm", 32'(o_PM), 1);
    edit(3, 1, 1, 1, 1);
    cyc();
    chk("inc_dec", 32'(o_Alarm_BCD), 32'h1100);
    edit(3, 0, 0, 1, 0);
    cyc();
    chk("hr0", 32'(o_Alarm_BCD), 32'h1200);
    chk("hr0_pm", 32'(o_PM), 0);
    set_hm(3, 13, 5);
    cyc();
    chk("hr13", 32'(o_Alarm_BCD), 32'h0105);
    chk("hr13_pm", 32'(o_PM), 1);

    set_hm(0, 6, 0);
    set_hm(2, 6, 0);
    toggle(0);
    toggle(2);
    set_time(359);
    set_time(360);
    chk("fire_02", 32'(o_Ring), 32'b0101);
    i_Sel = 0;
    i_Enable_Toggle = 1;
    i_Dismiss = 1;
    cyc();
    clr();
    chk("tog_dis_ring", 32'(o_Ring), 0);
    chk("tog_dis_en", 32'(o_Enabled), 32'b0110);
    set_time(359);
    set_time(360);
    chk("fire_2", 32'(o_Ring), 32'b0100);
    i_Reset = 1;
    cyc();
    chk("mid_rst_ring", 32'(o_Ring), 0);
    chk("mid_rst_en", 32'(o_Enabled), 0);
    chk("mid_rst_rg", 32'(o_Ringing), 0);
    chk("mid_rst_bcd", 32'(o_Alarm_BCD), 32'h1200);
    i_Reset = 0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
